processor_system: RTL and testbench
===================================

# processor_system

Multicycle 32-bit processor with its instruction ROM and data RAM, the compute core of the decryption design. It fetches from a 4096×32 ROM, executes a small fixed ISA, and reads and writes a 4096×32 RAM. It also reads a second ROM, the dictionary memory. The 32×32 register file is external and driven through the `ctrl_*`/`data_*` ports.

## Interface
Parameters:
- `MEMFILE`, default `""`: hex image loaded into ROM with `$readmemh`.
- `ADDRESS_WIDTH`, default 12: RAM/ROM address bits.
- `DEPTH`, default 4096: RAM/ROM words.
- `DATA_WIDTH`, default 32: word width.

Ports:
- `clock` in 1: single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `address_imem` out 32: PC.
- `q_imem` in 32: instruction from ROM.
- `ctrl_writeEnable` out 1; `ctrl_writeReg` out 5; `data_writeReg` out 32: register-file write port.
- `ctrl_readRegA` out 5; `ctrl_readRegB` out 5: register-file read addresses.
- `data_readRegA` in 32; `data_readRegB` in 32: register-file read data, combinational.
- `wren` out 1; `address_dmem` out 32; `data` out 32; `q_dmem` in 32: RAM port.
- `address_dictmem` out 32; `q_dictmem` in 32: dictionary-ROM port.

Memories:
- ROM(`clk`, `addr`[11:0], `dataOut`[31:0]).
- RAM(`clk`, `wEn`, `addr`[11:0], `dataIn`, `dataOut`).

## Operation
Instruction fields:
- `op`=[31:27], `rd`=[26:22], `rs`=[21:17], `rt`=[16:12], `shamt`=[11:7], `aluop`=[6:2].
- `N`=[16:0], sign-extended. `T`=[26:0], zero-extended.

Instructions:
- `op` 00000, R-type. `aluop`: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 sll by `shamt`, 00101 sra by `shamt`. Result $rd = $rs op $rt. Other `aluop` values are nop.
- 00101 addi: $rd = $rs + N.
- 01000 lw: $rd = RAM[$rs+N].
- 00111 sw: RAM[$rs+N] = $rd.
- 00001 j: PC = T.
- 00011 jal: r31 = PC+1, then PC = T.
- 00100 jr: PC = $rd.
- 00010 bne: if $rd != $rs, PC = PC+1+N.
- 00110 blt: if $rd < $rs (signed), PC = PC+1+N.
- 01001 lwd: $rd = DICT[$rs+N].
- Any other opcode is a nop.

Datapath rules:
- `ctrl_readRegA` = `rs`, always.
- `ctrl_readRegB` = `rd` for sw, bne, blt and jr; `rt` otherwise.
- Arithmetic is 32-bit two's-complement and wraps. There is no overflow exception.
- Memory addresses use bits [11:0] only and wrap modulo 4096.
- Writes with destination 0 are suppressed: `ctrl_writeEnable` stays 0.

ROM and RAM:
- ROM is initialised from `MEMFILE`.
- RAM powers up zero.
- Memory contents are unaffected by `reset`.

## Timing
Every instruction takes exactly 4 cycles through the states FETCH → EXEC → MEM → WB → FETCH.

- **FETCH**: `address_imem` = PC. ROM registers `q_imem` at the closing edge.
- **EXEC**: decode, operand read and ALU. The result and the effective address are latched at the closing edge.
- **MEM**:
  - `address_dmem`/`address_dictmem` carry the effective address.
  - For sw: `wren`=1 and `data`=$rd, for this cycle only; the write commits at the closing edge.
  - For lw/lwd: RAM/ROM registers the read data at the closing edge.
- **WB**:
  - `ctrl_writeEnable` is high for this cycle only, when the instruction writes a register.
  - Load data is taken from `q_dmem`/`q_dictmem`.
  - PC updates at the closing edge: to the next-PC (PC+1, or the jump/branch target).

Other timing rules:
- `address_imem` holds PC constant through all 4 states.
- RAM read-during-write to the same address returns the old data.
- Reset: at a rising edge with `reset`=1, PC=0 and state=FETCH. `wren`, `ctrl_writeEnable` and `address_imem` are forced to 0 while reset is high.
- Reset mid-instruction aborts the instruction. If it lands in MEM or WB, no RAM or register write occurs in that cycle.
- PC wraps at 32 bits. ROM sees PC[11:0].

## Configuration
- `DICT_LOAD_EN` defined: lwd is implemented as specified above.
- `DICT_LOAD_EN` undefined: opcode 01001 is a nop, and `address_dictmem` is tied to 0.

## Test plan
- `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2` → r3=2. Each write pulses `ctrl_writeEnable` in cycle 4 of its instruction. The 3 instructions take 12 cycles.
- `addi $1,$0,1500`; `addi $2,$0,77`; `sw $2,0($1)`; `lw $4,0($1)` → `wren` high for exactly 1 cycle with address 1500; r4=77.
- `addi $1,$0,7`; `bne $1,$0,+2` → 2 instructions skipped, next PC=4. `blt $0,$1,-1` loops while $0<$1.
- `jal 10` at PC 3 → r31=4 and PC=10. `jr $31` returns to PC 4.
- Assert `reset` during the MEM state of a sw → no RAM write; next fetch is from PC 0.
- With `DICT_LOAD_EN`: `lwd $5,2($0)` with DICT[2]=0x61 → r5=97. Without it → r5 unchanged and `address_dictmem`=0.

Source files
------------

// File: rtl/processor_system.sv
// processor_system: multicycle 32-bit core running FETCH -> EXEC -> MEM -> WB against external
//   instruction ROM, data RAM, dictionary ROM and register file. Latency: 4 cycles per instruction.
// Backpressure: none; all memories are fixed one-cycle synchronous reads, so the core never stalls.
// Optional feature: define DICT_LOAD_EN to implement lwd (opcode 01001); otherwise it is a nop
//   and address_dictmem is tied to 0.
// Ports: clock/reset (sync, active-high); address_imem/q_imem = ROM fetch (PC);
//   ctrl_readRegA/B + data_readRegA/B = register-file reads (combinational);
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg = register-file write (WB only);
//   wren/address_dmem/data/q_dmem = RAM; address_dictmem/q_dictmem = dictionary ROM.
module processor_system #(
  parameter MEMFILE = "",
  parameter int ADDRESS_WIDTH = 12,
  parameter int DEPTH = 4096,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [31:0]           address_imem,
  input  logic [DATA_WIDTH-1:0] q_imem,
  output logic                  ctrl_writeEnable,
  output logic [4:0]            ctrl_writeReg,
  output logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [4:0]            ctrl_readRegA,
  output logic [4:0]            ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_readRegA,
  input  logic [DATA_WIDTH-1:0] data_readRegB,
  output logic                  wren,
  output logic [31:0]           address_dmem,
  output logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] q_dmem,
  output logic [31:0]           address_dictmem,
  input  logic [DATA_WIDTH-1:0] q_dictmem
);

  // Memory image and depth belong to the external ROM/RAM instances; the core only
  // needs ADDRESS_WIDTH to wrap effective addresses.
  localparam int unused_depth   = DEPTH;
  localparam     unused_memfile = MEMFILE;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_LWD  = 5'b01001;

`ifdef DICT_LOAD_EN
  localparam bit DICT_EN = 1'b1;
`else
  localparam bit DICT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {FETCH, EXEC, MEM, WB} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, npc_q, npc;
  logic [DATA_WIDTH-1:0]   ir_q, res_q, b_q, alu_res, instr;
  logic [DATA_WIDTH-1:0]   n_ext, t_ext, a_val, b_val;
  logic [4:0]              op, rd, rs, rt, shamt, aluop;
  logic                    is_lwd, r_valid, writes_reg, use_rd_b;
  logic [31:0]             mem_addr;
  logic                    unused_instr_bits;

  // ROM output is valid from EXEC on; it is captured into ir_q so MEM/WB decode
  // does not depend on the ROM holding its output.
  assign instr = (state_q == EXEC) ? q_imem : ir_q;

  assign op    = instr[31:27];
  assign rd    = instr[26:22];
  assign rs    = instr[21:17];
  assign rt    = instr[16:12];
  assign shamt = instr[11:7];
  assign aluop = instr[6:2];
  assign n_ext = {{15{instr[16]}}, instr[16:0]};
  assign t_ext = {5'b0, instr[26:0]};
  assign unused_instr_bits = ^instr[1:0];

  assign is_lwd     = DICT_EN && (op == OP_LWD);
  assign r_valid    = (op == OP_R) && (aluop <= 5'd5);
  assign writes_reg = r_valid || (op == OP_ADDI) || (op == OP_LW) || is_lwd || (op == OP_JAL);
  assign use_rd_b   = (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);

  assign ctrl_readRegA = rs;
  assign ctrl_readRegB = use_rd_b ? rd : rt;
  assign a_val = data_readRegA;
  assign b_val = data_readRegB;

  // ALU and next-PC, evaluated during EXEC and latched at its closing edge.
  always_comb begin
    alu_res = '0;
    npc     = pc_q + 32'd1;
    case (op)
      OP_R: begin
        case (aluop)
          5'd0: alu_res = a_val + b_val;
          5'd1: alu_res = a_val - b_val;
          5'd2: alu_res = a_val & b_val;
          5'd3: alu_res = a_val | b_val;
          5'd4: alu_res = a_val << shamt;
          5'd5: alu_res = $signed(a_val) >>> shamt;
          default: alu_res = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_LWD: alu_res = a_val + n_ext;
      OP_J:   npc = t_ext;
      OP_JAL: begin
        alu_res = pc_q + 32'd1;
        npc     = t_ext;
      end
      OP_JR:  npc = b_val;
      OP_BNE: if (b_val != a_val) npc = pc_q + 32'd1 + n_ext;
      OP_BLT: if ($signed(b_val) < $signed(a_val)) npc = pc_q + 32'd1 + n_ext;
      default: ;
    endcase
  end

  // Next state plus the single-cycle write strobes; reset kills any write in flight.
  always_comb begin
    state_d          = state_q;
    wren             = 1'b0;
    ctrl_writeEnable = 1'b0;
    case (state_q)
      FETCH: state_d = EXEC;
      EXEC:  state_d = MEM;
      MEM: begin
        state_d = WB;
        wren    = (op == OP_SW) && !reset;
      end
      WB: begin
        state_d          = FETCH;
        ctrl_writeEnable = writes_reg && (ctrl_writeReg != 5'd0) && !reset;
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    data_writeReg = res_q;
    if (op == OP_LW)
      data_writeReg = q_dmem;
    else if (is_lwd)
      data_writeReg = q_dictmem;
  end

  assign ctrl_writeReg = (op == OP_JAL) ? 5'd31 : rd;
  assign mem_addr      = {{(32-ADDRESS_WIDTH){1'b0}}, res_q[ADDRESS_WIDTH-1:0]};
  assign address_dmem  = mem_addr;
  assign data          = b_q;
  assign address_imem  = reset ? 32'd0 : pc_q;

`ifdef DICT_LOAD_EN
  assign address_dictmem = mem_addr;
`else
  assign address_dictmem = 32'd0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) begin
        ir_q  <= q_imem;
        res_q <= alu_res;
        b_q   <= b_val;
        npc_q <= npc;
      end
      if (state_q == WB)
        pc_q <= npc_q;
    end
  end

endmodule

// File: tb/tb_processor_system.sv
module tb_processor_system;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_LWD  = 5'b01001;
  localparam logic [31:0] NOP    = 32'hF800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_imem, q_imem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg, ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_writeReg, data_readRegA, data_readRegB;
  logic        wren;
  logic [31:0] address_dmem, data, q_dmem, address_dictmem, q_dictmem;

  logic [31:0] rom  [0:4095];
  logic [31:0] dict [0:4095];
  logic [31:0] ram  [0:4095] = '{default: 32'h0};
  logic [31:0] rf   [0:31]   = '{default: 32'h0};

  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = 5'd0;
  logic [31:0] poke_val = 32'd0;

  int vectors = 0;
  int miscompares = 0;
  int cyc, we_count, wren_count;
  int we_cyc[$];
  logic [31:0] wren_addr, wren_dat;

  always #5 clock = ~clock;

  processor_system dut (
    .clock(clock), .reset(reset),
    .address_imem(address_imem), .q_imem(q_imem),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem),
    .address_dictmem(address_dictmem), .q_dictmem(q_dictmem)
  );

  // Memory and register-file models.
  always @(posedge clock) q_imem <= rom[address_imem[11:0]];
  always @(posedge clock) q_dictmem <= dict[address_dictmem[11:0]];
  always @(posedge clock) begin
    q_dmem <= ram[address_dmem[11:0]];
    if (wren) ram[address_dmem[11:0]] <= data;
  end
  always @(posedge clock) begin
    if (ctrl_writeEnable) rf[ctrl_writeReg] <= data_writeReg;
    else if (poke_en)     rf[poke_idx] <= poke_val;
  end
  assign data_readRegA = (ctrl_readRegA == 5'd0) ? 32'd0 : rf[ctrl_readRegA];
  assign data_readRegB = (ctrl_readRegB == 5'd0) ? 32'd0 : rf[ctrl_readRegB];

  // Cycle 1 is the first cycle after reset drops.
  always @(negedge clock) begin
    if (reset) begin
      cyc = 0; we_count = 0; wren_count = 0; we_cyc.delete();
    end else begin
      cyc++;
      if (ctrl_writeEnable) begin we_count++; we_cyc.push_back(cyc); end
      if (wren) begin wren_count++; wren_addr = address_dmem; wren_dat = data; end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input int n);
    return {op, rd, rs, n[16:0]};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu);
    return {5'b0, rd, rs, rt, sh, alu, 2'b0};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] op, input int t);
    return {op, t[26:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 4096; i++) rom[i] = NOP;
  endtask
  task automatic poke(input logic [4:0] idx, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = idx; poke_val = val;
    @(posedge clock); #1 poke_en = 1'b0;
  endtask
  task automatic release_reset();
    @(posedge clock); #1 reset = 1'b0;
  endtask
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) dict[i] = 32'd0;
    dict[2] = 32'h61;

    // Reset state and basic ALU/writeback timing.
    begin_test();
    chk("rst_address_imem", address_imem, 32'd0);
    chk("rst_wren", {31'd0, wren}, 32'd0);
    chk("rst_we", {31'd0, ctrl_writeEnable}, 32'd0);
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 5);
    rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, -3);
    rom[2] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd0);
    rom[3] = enc_j(OP_J, 3);
    release_reset();
    wait_cycles(1);
    chk("t1_first_fetch_pc", address_imem, 32'd0);
    wait_cycles(12);
    chk("t1_r1", rf[1], 32'd5);
    chk("t1_r2", rf[2], 32'hFFFF_FFFD);
    chk("t1_r3", rf[3], 32'd2);
    chk("t1_we_count", we_count, 32'd3);
    chk("t1_we_cyc0", we_cyc[0], 32'd4);
    chk("t1_we_cyc1", we_cyc[1], 32'd8);
    chk("t1_we_cyc2", we_cyc[2], 32'd12);
    chk("t1_pc_after_12", address_imem, 32'd3);

    // Store then load through RAM.
    begin_test();
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 1500);
    rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 77);
    rom[2] = enc_i(OP_SW, 5'd2, 5'd1, 0);
    rom[3] = enc_i(OP_LW, 5'd4, 5'd1, 0);
    rom[4] = enc_j(OP_J, 4);
    release_reset();
    wait_cycles(17);
    chk("t2_wren_count", wren_count, 32'd1);
    chk("t2_wren_addr", wren_addr, 32'd1500);
    chk("t2_wren_data", wren_dat, 32'd77);
    chk("t2_ram1500", ram[1500], 32'd77);
    chk("t2_r4", rf[4], 32'd77);

    // Taken bne skips two instructions; blt loops on itself.
    begin_test();
    poke(5'd6, 32'd0);
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 7);
    rom[1] = enc_i(OP_BNE, 5'd1, 5'd0, 2);
    rom[2] = enc_i(OP_ADDI, 5'd6, 5'd0, 99);
    rom[3] = enc_i(OP_ADDI, 5'd6, 5'd0, 99);
    rom[4] = enc_i(OP_BLT, 5'd0, 5'd1, -1);
    release_reset();
    wait_cycles(9);
    chk("t3_bne_target", address_imem, 32'd4);
    wait_cycles(4);
    chk("t3_blt_loop", address_imem, 32'd4);
    chk("t3_r6_skipped", rf[6], 32'd0);

    // jal / jr.
    begin_test();
    rom[3]  = enc_j(OP_JAL, 10);
    rom[4]  = enc_j(OP_J, 4);
    rom[10] = enc_i(OP_JR, 5'd31, 5'd0, 0);
    release_reset();
    wait_cycles(17);
    chk("t4_jal_pc", address_imem, 32'd10);
    chk("t4_r31", rf[31], 32'd4);
    wait_cycles(4);
    chk("t4_jr_pc", address_imem, 32'd4);

    // Reset landing in MEM of a store.
    begin_test();
    rom[0] = enc_i(OP_ADDI, 5'd1, 5'd0, 100);
    rom[1] = enc_i(OP_ADDI, 5'd2, 5'd0, 55);
    rom[2] = enc_i(OP_SW, 5'd2, 5'd1, 0);
    rom[3] = enc_j(OP_J, 3);
    release_reset();
    wait_cycles(11);
    chk("t5_mem_wren", {31'd0, wren}, 32'd1);
    chk("t5_mem_addr", address_dmem, 32'd100);
    chk("t5_mem_data", data, 32'd55);
    reset = 1'b1;
    #1;
    chk("t5_rst_wren", {31'd0, wren}, 32'd0);
    chk("t5_rst_address_imem", address_imem, 32'd0);
    @(posedge clock);
    @(posedge clock); #1 reset = 1'b0;
    chk("t5_no_ram_write", ram[100], 32'd0);
    wait_cycles(1);
    chk("t5_refetch_pc0", address_imem, 32'd0);

    // Dictionary load.
    begin_test();
    poke(5'd5, 32'h1234);
    rom[0] = enc_i(OP_LWD, 5'd5, 5'd0, 2);
    rom[1] = enc_j(OP_J, 1);
    release_reset();
    wait_cycles(3);
`ifdef DICT_LOAD_EN
    chk("t6_dict_addr", address_dictmem, 32'd2);
`else
    chk("t6_dict_addr", address_dictmem, 32'd0);
`endif
    wait_cycles(2);
`ifdef DICT_LOAD_EN
    chk("t6_r5", rf[5], 32'd97);
`else
    chk("t6_r5", rf[5], 32'h1234);
`endif

    // Remaining R-type ops, an undefined aluop, and a write to r0.
    begin_test();
    poke(5'd1, 32'hF0F0_0F0F);
    poke(5'd2, 32'h0FF0_00FF);
    poke(5'd8, 32'd0);
    rom[0] = enc_r(5'd3, 5'd1, 5'd2, 5'd0, 5'd1);
    rom[1] = enc_r(5'd4, 5'd1, 5'd2, 5'd0, 5'd2);
    rom[2] = enc_r(5'd5, 5'd1, 5'd2, 5'd0, 5'd3);
    rom[3] = enc_r(5'd6, 5'd1, 5'd0, 5'd4, 5'd4);
    rom[4] = enc_r(5'd7, 5'd1, 5'd0, 5'd4, 5'd5);
    rom[5] = enc_r(5'd8, 5'd1, 5'd2, 5'd0, 5'd7);
    rom[6] = enc_i(OP_ADDI, 5'd0, 5'd0, 5);
    rom[7] = enc_j(OP_J, 7);
    release_reset();
    wait_cycles(29);
    chk("t7_sub", rf[3], 32'hE100_0E10);
    chk("t7_and", rf[4], 32'h00F0_000F);
    chk("t7_or",  rf[5], 32'hFFF0_0FFF);
    chk("t7_sll", rf[6], 32'h0F00_F0F0);
    chk("t7_sra", rf[7], 32'hFF0F_00F0);
    chk("t7_bad_aluop", rf[8], 32'd0);
    chk("t7_we_count", we_count, 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
